// File: rtl/reg_int_gen.sv
// CPU register interface: RW control bank, status words, W1C interrupt
// register with mask, and an RMON counter read engine with timeout.
module reg_int_gen #(
    parameter int                         DATA_W    = 16,
    parameter int                         NUM_RW    = 40,
    parameter logic [NUM_RW*DATA_W-1:0]   RW_INIT   = '0,
    parameter logic [NUM_RW-1:0]          SC_MASK   = '0,
    parameter int                         NUM_ST    = 8,
    parameter int                         ST_BASE   = 48,
    parameter int                         IRQ_BASE  = 56,
    parameter int                         RMON_BASE = 60,
    parameter int                         RMON_TO   = 255
) (
    input  logic                       Clk_reg,
    input  logic                       Reset_n,
    input  logic                       CSB,
    input  logic                       WRB,
    input  logic [7:0]                 CA,
    input  logic [DATA_W-1:0]          CD_in,
    output logic [DATA_W-1:0]          CD_out,
    output logic [NUM_RW*DATA_W-1:0]   Rw_regs,
    input  logic [NUM_ST*DATA_W-1:0]   St_in,
    input  logic [DATA_W-1:0]          Event_in,
    output logic                       Irq,
    output logic [5:0]                 CPU_rd_addr,
    output logic                       CPU_rd_apply,
    input  logic                       CPU_rd_grant,
    input  logic [31:0]                CPU_rd_dout
);

    localparam int CNT_W = (RMON_TO > 1) ? $clog2(RMON_TO) : 1;
    localparam logic [6:0] A_IRQ  = 7'(IRQ_BASE);
    localparam logic [6:0] A_MASK = 7'(IRQ_BASE + 1);
    localparam logic [6:0] A_RM0  = 7'(RMON_BASE);
    localparam logic [6:0] A_RM1  = 7'(RMON_BASE + 1);
    localparam logic [6:0] A_RM2  = 7'(RMON_BASE + 2);
    localparam logic [6:0] A_RM3  = 7'(RMON_BASE + 3);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RMON_TO - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    logic [6:0]        addr;
    logic              wr_d, wr_q, wr_acc, rd_en;
    logic [DATA_W-1:0] rw_q [NUM_RW];
    logic [DATA_W-1:0] rw_d [NUM_RW];
    logic [DATA_W-1:0] pend_q, pend_d, mask_q, mask_d, clr;
    logic              irq_q;
    logic [DATA_W-1:0] rdata, cd_q, cd_d;
    state_e            state_q, state_d;
    logic [5:0]        raddr_q, raddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       snap_q, snap_d;
    logic              valid_q, valid_d, err_q, err_d;
    logic              start, to_hit, apply, busy;
    logic              unused_ca0;

    assign addr       = CA[7:1];
    assign unused_ca0 = CA[0];
    assign rd_en      = !CSB && WRB;
    assign wr_d       = !CSB && !WRB;
    // Edge-detect the write strobe so a held access writes once
    assign wr_acc     = wr_d && !wr_q;

    always_comb begin
        for (int i = 0; i < NUM_RW; i++) begin
            rw_d[i] = SC_MASK[i] ? '0 : rw_q[i];
            if (wr_acc && addr == 7'(i))
                rw_d[i] = CD_in;
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
        assign Rw_regs[g*DATA_W +: DATA_W] = rw_q[g];
    end

    // Set beats clear on a same-cycle collision
    assign clr    = (wr_acc && addr == A_IRQ) ? CD_in : '0;
    assign pend_d = (pend_q & ~clr) | Event_in;
    assign mask_d = (wr_acc && addr == A_MASK) ? CD_in : mask_q;

    assign start  = wr_acc && addr == A_RM0 && state_q == S_IDLE;
    assign to_hit = cnt_q == CNT_LAST;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_REQ;
            S_REQ:   if (CPU_rd_grant || to_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        apply = state_q == S_REQ;
        busy  = state_q == S_REQ;
    end

    assign CPU_rd_apply = apply;

    always_comb begin
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    raddr_d = CD_in[5:0];
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (CPU_rd_grant)
                    snap_d = CPU_rd_dout;
                else if (to_hit)
                    err_d = 1'b1;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE:  valid_d = !err_q;
            default: ;
        endcase
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (addr == 7'(i)) rdata = rw_q[i];
        for (int j = 0; j < NUM_ST; j++)
            if (addr == 7'(ST_BASE + j)) rdata = St_in[j*DATA_W +: DATA_W];
        if (addr == A_IRQ)  rdata = pend_q;
        if (addr == A_MASK) rdata = mask_q;
        if (addr == A_RM0)  rdata = DATA_W'(raddr_q);
        if (addr == A_RM1)  rdata = DATA_W'({err_q, valid_q, busy});
        if (addr == A_RM2)  rdata = snap_q[DATA_W-1:0];
        if (addr == A_RM3)  rdata = DATA_W'(snap_q >> DATA_W);
    end

    assign cd_d = rd_en ? rdata : '0;

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_RW; i++)
                rw_q[i] <= RW_INIT[i*DATA_W +: DATA_W];
            wr_q    <= 1'b0;
            pend_q  <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
            cd_q    <= '0;
        end else begin
            rw_q    <= rw_d;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            irq_q   <= |(pend_q & mask_q);
            cd_q    <= cd_d;
        end
    end

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            raddr_q <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign CD_out      = cd_q;
    assign Irq         = irq_q;
    assign CPU_rd_addr = raddr_q;

endmodule

// File: tb/tb_reg_int_gen.sv
// Scoreboard bench for reg_int_gen: directed scenarios, then randomized
// register traffic checked against a transaction-level model.
module tb_reg_int_gen;

    localparam int DW   = 16;
    localparam int NRW  = 40;
    localparam int NST  = 8;
    localparam int STB  = 48;
    localparam int IRQB = 56;
    localparam int RMB  = 60;
    localparam int TO   = 16;
    localparam logic [NRW-1:0] SCM = (40'd1 << 10) | (40'd1 << 20);

    function automatic logic [NRW*DW-1:0] mk_init();
        logic [NRW*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NRW; i++)
            r[i*DW +: DW] = 16'(i * 16'h0123 + 16'h0101);
        r[4*DW +: DW]  = 16'h000C;
        r[10*DW +: DW] = 16'h0000;
        r[20*DW +: DW] = 16'h0000;
        return r;
    endfunction

    localparam logic [NRW*DW-1:0] INIT = mk_init();

    logic              clk, rst_n, csb, wrb;
    logic [7:0]        ca;
    logic [DW-1:0]     cd_in, cd_out, ev;
    logic [NRW*DW-1:0] rw_regs;
    logic [NST*DW-1:0] st_in;
    logic              irq, apply, grant;
    logic [5:0]        rd_addr;
    logic [31:0]       dout;

    reg_int_gen #(
        .DATA_W(DW), .NUM_RW(NRW), .RW_INIT(INIT), .SC_MASK(SCM),
        .NUM_ST(NST), .ST_BASE(STB), .IRQ_BASE(IRQB),
        .RMON_BASE(RMB), .RMON_TO(TO)
    ) dut (
        .Clk_reg(clk), .Reset_n(rst_n), .CSB(csb), .WRB(wrb), .CA(ca),
        .CD_in(cd_in), .CD_out(cd_out), .Rw_regs(rw_regs), .St_in(st_in),
        .Event_in(ev), .Irq(irq), .CPU_rd_addr(rd_addr),
        .CPU_rd_apply(apply), .CPU_rd_grant(grant), .CPU_rd_dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model state
    logic [DW-1:0] rw_m [NRW];
    logic [DW-1:0] pend_m, mask_m, clr_now, mask_wdata;
    logic          mask_wr, irq_m;
    logic [5:0]    rmon_addr_m;
    logic [2:0]    rmon_st_m;
    logic [31:0]   snap_m;
    bit            ev_rand, mon_en, irq_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_m <= '0;
            mask_m <= '0;
            irq_m  <= 1'b0;
        end else begin
            pend_m <= (pend_m & ~clr_now) | ev;
            if (mask_wr) mask_m <= mask_wdata;
            irq_m  <= |(pend_m & mask_m);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NRW; i++) rw_m[i] = INIT[i*DW +: DW];
        rmon_addr_m = '0;
        rmon_st_m   = '0;
        snap_m      = '0;
    endtask

    function automatic logic [DW-1:0] model_rd(input int a);
        if (a < NRW) return rw_m[a];
        if (a >= STB && a < STB + NST) return st_in[(a-STB)*DW +: DW];
        if (a == IRQB) return pend_m;
        if (a == IRQB + 1) return mask_m;
        if (a == RMB) return {10'b0, rmon_addr_m};
        if (a == RMB + 1) return {13'b0, rmon_st_m};
        if (a == RMB + 2) return snap_m[15:0];
        if (a == RMB + 3) return snap_m[31:16];
        return '0;
    endfunction

    // Scoreboard
    logic [DW-1:0] exp_q [$];
    string         nm_q  [$];
    logic          rd_ph;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ph <= 1'b0;
        else rd_ph <= !csb && wrb;
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (rd_ph) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected: got %0h expected none",
                             cd_out);
                end else begin
                    logic [DW-1:0] e;
                    string         s;
                    e = exp_q.pop_front();
                    s = nm_q.pop_front();
                    chk(s, cd_out, e);
                end
            end else begin
                chk("cd_idle", cd_out, 0);
            end
            if (irq_en) chk("irq_model", irq, irq_m);
        end
    end

    function automatic logic [DW-1:0] rnd_ev();
        return ev_rand ? 16'($urandom & $urandom & $urandom) : '0;
    endfunction

    task automatic idle_bus();
        csb = 1'b1; wrb = 1'b1; ca = '0; cd_in = '0; ev = '0;
        clr_now = '0; mask_wr = 1'b0; mask_wdata = '0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d,
                            input logic [DW-1:0] e = '0);
        @(negedge clk);
        csb = 1'b0; wrb = 1'b0; ca = {7'(a), 1'b0}; cd_in = d;
        ev = e | rnd_ev();
        if (a < NRW) rw_m[a] = SCM[a] ? '0 : d;
        if (a == IRQB) clr_now = d;
        if (a == IRQB + 1) begin mask_wr = 1'b1; mask_wdata = d; end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic do_read(input int a, input string nm,
                           input bit use_exp = 0,
                           input logic [DW-1:0] exp = '0);
        @(negedge clk);
        csb = 1'b0; wrb = 1'b1; ca = {7'(a), 1'b0}; ev = rnd_ev();
        exp_q.push_back(use_exp ? exp : model_rd(a));
        nm_q.push_back(nm);
        @(negedge clk);
        idle_bus();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        idle_bus();
        rst_n = 1'b0; grant = 1'b0; dout = '0; st_in = '0;
        ev_rand = 0; mon_en = 0; irq_en = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cd_out", cd_out, 0);
        chk("rst_irq", irq, 0);
        chk("rst_apply", apply, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rw_regs", rw_regs == INIT, 1);
        rst_n = 1'b1;
        mon_en = 1;

        // Reset value and held strobe
        do_read(4, "rst_word4", 1, 16'h000C);
        @(negedge clk);
        csb = 1'b0; wrb = 1'b0; ca = 8'h08; cd_in = 16'h0012;
        rw_m[4] = 16'h0012;
        @(negedge clk);
        cd_in = 16'h0099;
        repeat (4) @(negedge clk);
        idle_bus();
        do_read(4, "held_wr_once", 1, 16'h0012);

        // Self-clearing register
        @(negedge clk);
        csb = 1'b0; wrb = 1'b0; ca = 8'd20; cd_in = 16'h0001;
        @(negedge clk);
        idle_bus();
        chk("sc_pulse_hi", rw_regs[10*DW +: DW], 16'h0001);
        @(negedge clk);
        chk("sc_pulse_lo", rw_regs[10*DW +: DW], 16'h0000);
        @(negedge clk);
        csb = 1'b0; wrb = 1'b0; ca = 8'd20; cd_in = 16'h0003;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 4) idle_bus();
            if (rw_regs[10*DW +: DW] != 0) cnt++;
        end
        chk("sc_held_cycles", cnt, 1);
        do_read(10, "sc_read_zero", 1, 16'h0000);

        // W1C pending and interrupt
        do_write(IRQB + 1, 16'h0004);
        @(negedge clk);
        ev = 16'h0005;
        @(negedge clk);
        ev = '0;
        chk("irq_lat1", irq, 0);
        @(negedge clk);
        chk("irq_lat2", irq, 1);
        do_write(IRQB, 16'h0004, 16'h0004);
        do_read(IRQB, "w1c_set_wins", 1, 16'h0005);
        do_write(IRQB, 16'h0004);
        do_read(IRQB, "w1c_clear", 1, 16'h0001);
        chk("irq_cleared", irq, 0);
        do_read(IRQB + 1, "mask_rd", 1, 16'h0004);

        // RMON granted read
        do_write(RMB, 16'h0023);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (apply) begin
                cnt++;
                if (cnt == 1) chk("rmon_addr", rd_addr, 6'h23);
                if (cnt == 7) begin grant = 1'b1; dout = 32'hDEADBEEF; end
            end
            @(negedge clk);
            grant = 1'b0; dout = '0;
        end
        chk("grant_apply_cycles", cnt, 7);
        rmon_addr_m = 6'h23; rmon_st_m = 3'b010; snap_m = 32'hDEADBEEF;
        do_read(RMB + 1, "rmon_st_ok", 1, 16'h0002);
        do_read(RMB + 2, "rmon_lo", 1, 16'hBEEF);
        do_read(RMB + 3, "rmon_hi", 1, 16'hDEAD);
        do_read(RMB, "rmon_addr_rd", 1, 16'h0023);
        @(negedge clk);
        grant = 1'b1; dout = 32'h12345678;
        @(negedge clk);
        grant = 1'b0; dout = '0;
        chk("grant_idle_apply", apply, 0);
        do_read(RMB + 2, "grant_idle_ignored", 1, 16'hBEEF);

        // RMON timeout with a write while busy
        do_write(RMB, 16'h0015);
        cnt = 0;
        fork
            for (int k = 0; k < 40; k++) begin
                if (apply) cnt++;
                @(negedge clk);
            end
            begin
                repeat (3) @(negedge clk);
                do_write(RMB, 16'h003F);
            end
        join
        chk("to_apply_cycles", cnt, TO);
        chk("to_addr_kept", rd_addr, 6'h15);
        rmon_addr_m = 6'h15; rmon_st_m = 3'b100;
        do_read(RMB + 1, "rmon_st_err", 1, 16'h0004);
        do_read(RMB, "busy_wr_ignored", 1, 16'h0015);
        do_read(RMB + 2, "to_snap_kept", 1, 16'hBEEF);

        // Reset in the middle of a request
        do_write(5, 16'h5A5A);
        do_write(IRQB + 1, 16'h0001);
        repeat (2) @(negedge clk);
        chk("irq_pre_rst", irq, 1);
        do_write(RMB, 16'h002A);
        @(negedge clk);
        chk("apply_pre_rst", apply, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_apply", apply, 0);
        chk("rst_async_irq", irq, 0);
        chk("rst_async_addr", rd_addr, 0);
        chk("rst_async_cd", cd_out, 0);
        chk("rst_async_rw", rw_regs == INIT, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(RMB + 1, "rst_rmon_st", 1, 16'h0000);
        do_read(RMB + 2, "rst_snap_lo", 1, 16'h0000);
        do_read(RMB + 3, "rst_snap_hi", 1, 16'h0000);
        do_read(IRQB, "rst_pend", 1, 16'h0000);
        do_read(IRQB + 1, "rst_mask", 1, 16'h0000);
        do_read(5, "rst_word5", 1, INIT[5*DW +: DW]);

        // Randomized traffic against the model
        irq_en = 1;
        ev_rand = 1;
        for (int n = 0; n < 300; n++) begin
            int a;
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0: do_write($urandom_range(0, NRW - 1), 16'($urandom));
                1: do_read($urandom_range(0, NRW - 1), "rnd_rw");
                2: begin
                    st_in = {$urandom, $urandom, $urandom, $urandom};
                    do_read(STB + $urandom_range(0, NST - 1), "rnd_st");
                end
                3: do_write(STB + $urandom_range(0, NST - 1), 16'($urandom));
                4, 5: begin
                    case ($urandom_range(0, 2))
                        0: a = $urandom_range(NRW, STB - 1);
                        1: a = $urandom_range(IRQB + 2, RMB - 1);
                        default: a = $urandom_range(RMB + 4, 127);
                    endcase
                    if (op == 4) do_read(a, "rnd_unmapped");
                    else do_write(a, 16'($urandom));
                end
                6: do_write(IRQB + 1, 16'($urandom));
                7: do_read(IRQB + $urandom_range(0, 1), "rnd_irq_regs");
                8: do_write(IRQB, 16'($urandom));
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        do_write(RMB + $urandom_range(1, 3), 16'($urandom));
                    else
                        do_read(RMB + $urandom_range(0, 3), "rnd_rmon");
                end
            endcase
        end
        ev_rand = 0;
        irq_en = 0;
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_int_gen.md
Name: reg_int_gen

Overview:
- Parametrised CPU register interface; successor to the fixed 35-register MAC control block.
- Provides a configurable bank of RW control registers, including self-clearing pulse registers.
- Provides read-only status words, a sticky W1C event/interrupt register with mask, and an RMON 32-bit counter read engine with request/grant handshake and timeout.
- Sits between the CPU bus (CSB/WRB/CA/CD) and the MAC Tx/Rx/RMON/PHY blocks.

Parameters:
- DATA_W, 16: register width. Legal range 8..32.
- NUM_RW, 40: RW control registers at word addresses 0..NUM_RW-1.
- RW_INIT, 0: packed reset values, NUM_RW*DATA_W bits. Register i is at [i*DATA_W +: DATA_W].
- SC_MASK, 0: NUM_RW bits. Bit i=1 makes register i self-clearing (pulse register).
- NUM_ST, 8: read-only status words.
- ST_BASE, 48: word address of status word 0.
- IRQ_BASE, 56: W1C pending register. IRQ_BASE+1 is the RW mask.
- RMON_BASE, 60: RMON window, 4 words.
- RMON_TO, 255: grant timeout in cycles. Minimum 1.
- Legality: NUM_RW<=ST_BASE, ST_BASE+NUM_ST<=IRQ_BASE, IRQ_BASE+2<=RMON_BASE, RMON_BASE+3<=127.

Ports:
- Clk_reg  in  1  register clock.
- Reset_n  in  1  asynchronous, active-low reset.
- CSB  in  1  chip select, active low.
- WRB  in  1  0=write, 1=read.
- CA  in  8  byte address; word address is CA[7:1].
- CD_in  in  DATA_W  write data.
- CD_out  out  DATA_W  registered read data.
- Rw_regs  out  NUM_RW*DATA_W  packed control register values.
- St_in  in  NUM_ST*DATA_W  packed status inputs.
- Event_in  in  DATA_W  per-bit event pulses.
- Irq  out  1  interrupt, registered.
- CPU_rd_addr  out  6  RMON counter address.
- CPU_rd_apply  out  1  RMON read request.
- CPU_rd_grant  in  1  RMON grant; CPU_rd_dout is valid in the same cycle.
- CPU_rd_dout  in  32  RMON counter data.

Behaviour:
- Reset (Reset_n=0, asynchronous): Rw_regs=RW_INIT, pending=0, mask=0, Irq=0, CD_out=0, CPU_rd_addr=0, CPU_rd_apply=0, snapshot=0, valid=0, err=0, FSM=IDLE, timeout counter=0, wr_q=0.
- Write acceptance: a write is accepted when !CSB&&!WRB and wr_q==0, where wr_q is that condition registered. A held strobe writes exactly once per access. This replaces the old level-sensitive write.
- Writes to status addresses, unmapped addresses, RMON_BASE+1..+3, and RMON_BASE while busy are ignored.
- RW register i updates on the cycle after acceptance.
- If SC_MASK[i]=1, register i holds the written value for exactly 1 cycle, then returns to 0. A new write on the clear cycle wins.
- Read: when !CSB&&WRB, CD_out is loaded next cycle from the addressed word. Otherwise CD_out=0. Unmapped addresses return 0. Latency is 1 cycle.
- Read map:
  - RW address: register value.
  - Status address: St_in word, sampled at the read cycle.
  - IRQ_BASE: pending.
  - IRQ_BASE+1: mask.
  - RMON_BASE: {0, CPU_rd_addr}.
  - RMON_BASE+1: {0, err, valid, busy} in bits [2:0].
  - RMON_BASE+2: snapshot[DATA_W-1:0].
  - RMON_BASE+3: snapshot>>DATA_W, truncated or zero-extended to DATA_W.
- Pending register:
  - Each cycle, pending |= Event_in.
  - A write to IRQ_BASE clears the bits set in CD_in.
  - If an event and a clear hit the same bit in the same cycle, set wins.
- Irq is registered: Irq <= |(pending & mask). It updates 1 cycle after pending/mask.
- RMON FSM, states IDLE, REQ, DONE:
  - IDLE, accepted write to RMON_BASE: CPU_rd_addr <= CD_in[5:0], valid <= 0, err <= 0, counter <= 0, go to REQ.
  - REQ: CPU_rd_apply=1 and busy=1.
    - On CPU_rd_grant: snapshot <= CPU_rd_dout, go to DONE.
    - If no grant and counter==RMON_TO-1: err <= 1, go to DONE; snapshot is unchanged.
    - Otherwise counter increments.
  - DONE: CPU_rd_apply=0. Set valid=1 if the request was granted. Go to IDLE next cycle.
  - Grant and timeout in the same cycle: grant wins.
  - CPU_rd_apply is combinational from the state: high exactly in REQ.
  - Grant arriving in IDLE or DONE is ignored.
- Reset mid-request: immediate return to IDLE with apply=0. Snapshot, valid and err are cleared.

Test Plan:
- Reset value, held strobe: with RW_INIT word 4=0x000C, release reset and read addr 4 (CA=0x08) → CD_out=0x000C one cycle after the read. Then write 0x0012 with CSB/WRB held low for 5 cycles → exactly one write. Read back → 0x0012.
- Self-clearing register: SC_MASK[10]=1; write 0x0001 to word 10 → Rw_regs word 10 = 1 for exactly 1 cycle, then 0.
- W1C and interrupt: pulse Event_in=0x0005 and set mask=0x0004 → Irq=1 two cycles after the event. Write 0x0004 to IRQ_BASE in the same cycle as an Event_in bit2 pulse → pending stays 0x0005. A second clear → pending 0x0001, Irq=0.
- RMON grant: write 0x0023 to RMON_BASE; grant after 7 cycles with dout=0xDEADBEEF → apply high for 7 cycles. Status reads 0b010. Word +2 = 0xBEEF, word +3 = 0xDEAD.
- RMON timeout and busy: RMON_TO=16, never grant → apply high for exactly 16 cycles, then status 0b100. A second RMON_BASE write issued while busy → ignored; CPU_rd_addr unchanged.
- Reset mid-request: assert Reset_n=0 during REQ → apply=0 asynchronously. All outputs return to their reset values.
